// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and saturation helpers for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LHB = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Helpers work on a fixed wide signed value so any WIDTH up to MAX_W fits.
  localparam int MAX_W = 64;
  typedef logic signed [2*MAX_W-1:0] wide_t;
  typedef logic [2*MAX_W:0]          sat_t;   // {overflow, clamped value}

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic sat_t sat_from_2w(input wide_t p, input int w);
    sat_t r;
    if (p > sat_max(w))      r = {1'b1, sat_max(w)};
    else if (p < sat_min(w)) r = {1'b1, sat_min(w)};
    else                     r = {1'b0, p};
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between decode (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic [SHW-1:0]   shamt;
  logic             set_zr;
  logic             out_valid;
  logic [WIDTH-1:0] dst;
  logic             ov;
  logic             zr;
  logic             ne;

  modport master (
    output in_valid, ctrl, src0, src1, shamt, set_zr,
    input  in_ready, out_valid, dst, ov, zr, ne
  );

  modport slave (
    input  in_valid, ctrl, src0, src1, shamt, set_zr,
    output in_ready, out_valid, dst, ov, zr, ne
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  // High during the cycle whose edge performs the final step.
  assign last_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplr_q  <= b_i;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (mplr_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
      if (last_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered saturating ALU with a flag register and an iterative signed multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int HW  = WIDTH / 2;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic             zr_en;
  } req_t;

  state_e           state_q;
  req_t             req_q;
  logic             vld_q;
  logic             mul_neg_q, mul_zr_q;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic             ov_q, ov_d, zr_q, zr_d, ne_q, ne_d;
  logic             out_valid_q, out_valid_d;

  logic accept, accept_mul;

  // The DONE cycle already counts as ready, so a held request is taken while
  // the product is written and its result lands on the following edge.
  assign bus.in_ready = !rst && (state_q != BUSY);
  assign accept       = bus.in_valid && bus.in_ready;
  assign accept_mul   = accept && (bus.ctrl == OP_MUL);

  // Multiplier works on magnitudes; MIN maps to 2^(W-1), which fits unsigned.
  logic [WIDTH-1:0]   mag0, mag1;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod;

  assign mag0 = bus.src0[WIDTH-1] ? -bus.src0 : bus.src0;
  assign mag1 = bus.src1[WIDTH-1] ? -bus.src1 : bus.src1;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept_mul),
    .a_i     (mag0),
    .b_i     (mag1),
    .last_o  (mul_last),
    .prod_o  (prod)
  );

  // Exact W+1-bit sum/difference, then clamp; this also covers src1 == MIN.
  logic signed [WIDTH:0]     add_x, sub_x;
  logic signed [2*WIDTH-1:0] mul_p;
  sat_t                      add_s, sub_s, mul_s;

  assign add_x = {req_q.a[WIDTH-1], req_q.a} + {req_q.b[WIDTH-1], req_q.b};
  assign sub_x = {req_q.a[WIDTH-1], req_q.a} - {req_q.b[WIDTH-1], req_q.b};
  assign mul_p = mul_neg_q ? -prod : prod;
  assign add_s = sat_from_2w(wide_t'(add_x), WIDTH);
  assign sub_s = sat_from_2w(wide_t'(sub_x), WIDTH);
  assign mul_s = sat_from_2w(wide_t'(mul_p), WIDTH);

  logic unused_hi;
  assign unused_hi = ^{add_s[2*MAX_W-1:WIDTH], sub_s[2*MAX_W-1:WIDTH],
                       mul_s[2*MAX_W-1:WIDTH]};

  logic [WIDTH-1:0] sc_res;
  logic             sc_ov, sc_arith;

  always_comb begin
    sc_res   = '0;
    sc_ov    = 1'b0;
    sc_arith = 1'b0;
    case (req_q.op)
      OP_ADD: begin
        sc_res   = add_s[WIDTH-1:0];
        sc_ov    = add_s[2*MAX_W];
        sc_arith = 1'b1;
      end
      OP_SUB: begin
        sc_res   = sub_s[WIDTH-1:0];
        sc_ov    = sub_s[2*MAX_W];
        sc_arith = 1'b1;
      end
      OP_LHB:  sc_res = {req_q.b[WIDTH-1:HW], req_q.a[HW-1:0]};
      OP_AND:  sc_res = req_q.a & req_q.b;
      OP_NOR:  sc_res = ~(req_q.a | req_q.b);
      OP_SLL:  sc_res = req_q.b << req_q.sh;
      OP_SRL:  sc_res = req_q.b >> req_q.sh;
      OP_SRA:  sc_res = $signed(req_q.b) >>> req_q.sh;
      default: sc_res = '0;
    endcase
  end

  // A single-cycle result and a multiply result can never share an edge.
  always_comb begin
    dst_d       = dst_q;
    ov_d        = ov_q;
    zr_d        = zr_q;
    ne_d        = ne_q;
    out_valid_d = 1'b0;
    if (vld_q) begin
      dst_d       = sc_res;
      out_valid_d = 1'b1;
      if (sc_arith) begin
        ov_d = sc_ov;
        ne_d = sc_res[WIDTH-1];
      end
      if (req_q.zr_en) zr_d = (sc_res == '0);
    end else if (state_q == DONE) begin
      dst_d       = mul_s[WIDTH-1:0];
      out_valid_d = 1'b1;
      ov_d        = mul_s[2*MAX_W];
      ne_d        = mul_s[WIDTH-1];
      if (mul_zr_q) zr_d = (mul_s[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      vld_q       <= 1'b0;
      mul_neg_q   <= 1'b0;
      mul_zr_q    <= 1'b0;
      dst_q       <= '0;
      ov_q        <= 1'b0;
      zr_q        <= 1'b0;
      ne_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      vld_q <= accept && !accept_mul;
      if (accept) begin
        req_q.op    <= bus.ctrl;
        req_q.a     <= bus.src0;
        req_q.b     <= bus.src1;
        req_q.sh    <= bus.shamt;
        req_q.zr_en <= bus.set_zr;
      end
      if (accept_mul) begin
        mul_neg_q <= bus.src0[WIDTH-1] ^ bus.src1[WIDTH-1];
        mul_zr_q  <= bus.set_zr;
      end
      dst_q       <= dst_d;
      ov_q        <= ov_d;
      zr_q        <= zr_d;
      ne_q        <= ne_d;
      out_valid_q <= out_valid_d;
      case (state_q)
        IDLE:    if (accept_mul) state_q <= BUSY;
        BUSY:    if (mul_last) state_q <= DONE;
        DONE:    state_q <= accept_mul ? BUSY : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dst       = dst_q;
  assign bus.ov        = ov_q;
  assign bus.zr        = zr_q;
  assign bus.ne        = ne_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=16: directed table, multi-cycle corner sequences, random ops vs model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  logic m_ov, m_zr, m_ne;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  sh;
    logic        ze;
    logic [15:0] dst;
    logic        ov, zr, ne;
  } vec_t;

  typedef struct {
    logic [15:0] dst;
    logic        ov, zr, ne;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] sh, input logic ze, input logic [15:0] d,
                              input logic o, input logic z, input logic n);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.ze = ze;
    v.dst = d; v.ov = o; v.zr = z; v.ne = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, then clamp to the signed 16-bit range.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, output logic [15:0] r, output logic o,
                       output logic ar);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = 0; r = '0; o = 1'b0; ar = 1'b0;
    case (op)
      4'd0: begin t = sa + sb; ar = 1'b1; end
      4'd1: r = {b[15:8], a[7:0]};
      4'd2: begin t = sa - sb; ar = 1'b1; end
      4'd3: r = a & b;
      4'd4: r = ~(a | b);
      4'd5: r = b << sh;
      4'd6: r = b >> sh;
      4'd7: r = 16'(sb >>> sh);
      4'd8: begin t = sa * sb; ar = 1'b1; end
      default: r = '0;
    endcase
    if (ar) begin
      if (t > 32767)       begin r = 16'h7FFF; o = 1'b1; end
      else if (t < -32768) begin r = 16'h8000; o = 1'b1; end
      else                 r = t[15:0];
    end
  endtask

  task automatic ref_step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh, input logic ze, output exp_t e);
    logic [15:0] r;
    logic        o, ar;
    model(op, a, b, sh, r, o, ar);
    if (ar) begin m_ov = o; m_ne = r[15]; end
    if (ze) m_zr = (r == 16'h0);
    e.dst = r; e.ov = m_ov; e.zr = m_zr; e.ne = m_ne;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      4:       return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic ze);
    bus.ctrl = op; bus.src0 = a; bus.src1 = b; bus.shamt = sh; bus.set_zr = ze;
    bus.in_valid = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] sh, input logic ze,
                       input logic [15:0] e_dst, input logic e_ov, input logic e_zr,
                       input logic e_ne);
    int w, lat;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!bus.in_ready) begin
      chk({tag, " ready"}, 32'(bus.in_ready), 32'd1);
      return;
    end
    drive(op, a, b, sh, ze);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 40);
    chk({tag, " latency"}, 32'(lat), (op == 4'd8) ? 32'd17 : 32'd1);
    chk({tag, " dst"}, 32'(bus.dst), 32'(e_dst));
    chk({tag, " ov"}, 32'(bus.ov), 32'(e_ov));
    chk({tag, " zr"}, 32'(bus.zr), 32'(e_zr));
    chk({tag, " ne"}, 32'(bus.ne), 32'(e_ne));
  endtask

  initial begin
    exp_t        e;
    logic [3:0]  op, sh;
    logic [15:0] a, b;
    logic        ze;
    int          lat, busy, cnt;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ctrl = '0; bus.src0 = '0; bus.src1 = '0;
    bus.shamt = '0; bus.set_zr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst dst", 32'(bus.dst), 32'd0);
    chk("rst flags", 32'({bus.ov, bus.zr, bus.ne}), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table: op, a, b, shamt, set_zr -> dst, ov, zr, ne (flags accumulate)
    tbl.push_back(mk(4'd0, 16'h7000, 16'h2000, 4'd0,  1'b0, 16'h7FFF, 1, 0, 0));
    tbl.push_back(mk(4'd0, 16'h0001, 16'h0002, 4'd0,  1'b0, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(4'd2, 16'h8000, 16'h0001, 4'd0,  1'b0, 16'h8000, 1, 0, 1));
    tbl.push_back(mk(4'd2, 16'h0005, 16'h0005, 4'd0,  1'b1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(4'd4, 16'h0000, 16'h0000, 4'd0,  1'b0, 16'hFFFF, 0, 1, 0));
    tbl.push_back(mk(4'd7, 16'h0000, 16'h8888, 4'd8,  1'b1, 16'hFF88, 0, 0, 0));
    tbl.push_back(mk(4'd1, 16'h1234, 16'hABCD, 4'd0,  1'b0, 16'hAB34, 0, 0, 0));
    tbl.push_back(mk(4'd5, 16'h0000, 16'h0003, 4'd15, 1'b1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(4'd6, 16'h0000, 16'h8000, 4'd15, 1'b0, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(4'd2, 16'h0000, 16'h8000, 4'd0,  1'b0, 16'h7FFF, 1, 0, 0));
    tbl.push_back(mk(4'd3, 16'hF0F0, 16'h0FF0, 4'd0,  1'b1, 16'h00F0, 1, 0, 0));
    tbl.push_back(mk(4'd12, 16'h1234, 16'h5678, 4'd3, 1'b1, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(4'd0, 16'h8000, 16'hFFFF, 4'd0,  1'b0, 16'h8000, 1, 1, 1));
    tbl.push_back(mk(4'd2, 16'h7FFF, 16'hFFFF, 4'd0,  1'b0, 16'h7FFF, 1, 1, 0));
    tbl.push_back(mk(4'd8, 16'h0100, 16'h0100, 4'd0,  1'b0, 16'h7FFF, 1, 1, 0));
    tbl.push_back(mk(4'd8, 16'hFFFD, 16'h0007, 4'd0,  1'b0, 16'hFFEB, 0, 1, 1));
    tbl.push_back(mk(4'd8, 16'h8000, 16'hFFFF, 4'd0,  1'b0, 16'h7FFF, 1, 1, 0));
    tbl.push_back(mk(4'd8, 16'h0000, 16'h8000, 4'd0,  1'b1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(4'd8, 16'h8000, 16'h8000, 4'd0,  1'b1, 16'h7FFF, 1, 0, 0));
    tbl.push_back(mk(4'd8, 16'h00B5, 16'h00B4, 4'd0,  1'b0, 16'h7F44, 0, 0, 0));
    tbl.push_back(mk(4'd8, 16'h7FFF, 16'hFFFF, 4'd0,  1'b0, 16'h8001, 0, 0, 1));
    tbl.push_back(mk(4'd8, 16'h0100, 16'hFF80, 4'd0,  1'b0, 16'h8000, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++)
      do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].ze,
            tbl[i].dst, tbl[i].ov, tbl[i].zr, tbl[i].ne);
    m_ov = 1'b0; m_zr = 1'b0; m_ne = 1'b1;

    // MUL with an AND held pending throughout BUSY; AND must go in on the DONE cycle
    drive(4'd8, 16'hFFFD, 16'h0007, 4'd0, 1'b0);
    @(posedge clk); #1;
    drive(4'd3, 16'hF0F0, 16'h0FF0, 4'd0, 1'b0);
    busy = bus.in_ready ? 0 : 1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (!bus.in_ready) busy++;
    end while (!bus.out_valid && lat < 40);
    bus.in_valid = 1'b0;
    chk("held busy cycles", 32'(busy), 32'd16);
    chk("held mul latency", 32'(lat), 32'd17);
    chk("held mul dst", 32'(bus.dst), 32'hFFEB);
    chk("held mul ov/ne", 32'({bus.ov, bus.ne}), 32'b01);
    @(posedge clk); #1;
    chk("held and out_valid", 32'(bus.out_valid), 32'd1);
    chk("held and dst", 32'(bus.dst), 32'h00F0);
    chk("held and ov/zr/ne", 32'({bus.ov, bus.zr, bus.ne}), 32'b001);
    @(posedge clk); #1;
    chk("held pulse drop", 32'(bus.out_valid), 32'd0);

    // Back-to-back single-cycle burst: one result per cycle, two edges behind issue
    for (int k = 0; k < 22; k++) begin
      if (k >= 2) begin
        e = expq.pop_front();
        chk($sformatf("b2b%0d out_valid", k - 2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("b2b%0d dst", k - 2), 32'(bus.dst), 32'(e.dst));
        chk($sformatf("b2b%0d flags", k - 2), 32'({bus.ov, bus.zr, bus.ne}),
            32'({e.ov, e.zr, e.ne}));
      end
      if (k < 20) begin
        chk($sformatf("b2b%0d ready", k), 32'(bus.in_ready), 32'd1);
        do op = 4'($urandom_range(0, 15)); while (op == 4'd8);
        a = pick(); b = pick(); sh = 4'($urandom_range(0, 15)); ze = 1'($urandom_range(0, 1));
        ref_step(op, a, b, sh, ze, e);
        expq.push_back(e);
        drive(op, a, b, sh, ze);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Random ops, MUL weighted up
    for (int i = 0; i < 120; i++) begin
      cnt = int'($urandom_range(0, 19));
      op = (cnt < 16) ? 4'(cnt) : 4'd8;
      a = pick(); b = pick(); sh = 4'($urandom_range(0, 15)); ze = 1'($urandom_range(0, 1));
      ref_step(op, a, b, sh, ze, e);
      do_op($sformatf("rnd%0d", i), op, a, b, sh, ze, e.dst, e.ov, e.zr, e.ne);
    end

    // Reset in the middle of a multiply; make every output nonzero first
    do_op("pre-rst sub0", 4'd2, 16'h0005, 16'h0005, 4'd0, 1'b1, 16'h0000, 0, 1, 0);
    do_op("pre-rst sub1", 4'd2, 16'h8000, 16'h0001, 4'd0, 1'b0, 16'h8000, 1, 1, 1);
    drive(4'd8, 16'h0100, 16'h0100, 4'd0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst in_ready low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst dst", 32'(bus.dst), 32'd0);
    chk("midrst flags", 32'({bus.ov, bus.zr, bus.ne}), 32'd0);
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    chk("midrst stray out_valid", 32'(cnt), 32'd0);
    m_ov = 1'b0; m_zr = 1'b0; m_ne = 1'b0;
    do_op("post-rst add", 4'd0, 16'h0001, 16'h0002, 4'd0, 1'b0, 16'h0003, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
